// File: rtl/keyboard_buf.sv
// Receive-side keyboard character FIFO: queues 7-bit ASCII codes from the
// serial receiver and presents the oldest one (show-ahead) to the CPU.
module keyboard_buf #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned PTR_W = $clog2(DEPTH)
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       KB_read_en,
  input  logic       KB_clear,
  input  logic [7:0] rx_data,
  input  logic       rx_done,
  output logic       KB_status,
  output logic [6:0] KB_data,
  output logic       buf_full
);

  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W + 1)'(1);
  localparam logic [PTR_W:0]   CNT_FULL = (PTR_W + 1)'(DEPTH);

  logic [6:0]       mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic             rx_done_d;
  logic             rd_en_d;

  logic push_req;
  logic pop_req;
  logic empty;
  logic full;
  logic do_push;
  logic do_pop;

  assign push_req = rx_done & ~rx_done_d;
  assign pop_req  = KB_read_en & ~rd_en_d;
  assign empty    = (count == '0);
  assign full     = (count == CNT_FULL);

  // Both gates use the pre-edge count: an empty buffer ignores the pop and a
  // full one drops the push even when the other side frees/fills a slot.
  assign do_push  = push_req & ~full;
  assign do_pop   = pop_req & ~empty;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_done_d <= 1'b0;
      rd_en_d   <= 1'b0;
    end else begin
      rx_done_d <= rx_done;
      rd_en_d   <= KB_read_en;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (KB_clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !KB_clear) begin
      mem[wr_ptr] <= rx_data[6:0];
    end
  end

  assign KB_status = ~empty;
  assign buf_full  = full;
  assign KB_data   = empty ? '0 : mem[rd_ptr];

endmodule

// File: tb/tb_keyboard_buf.sv
// Directed self-checking bench for keyboard_buf.
module tb_keyboard_buf;

  logic       clk;
  logic       reset;
  logic       KB_read_en;
  logic       KB_clear;
  logic [7:0] rx_data;
  logic       rx_done;
  logic       KB_status;
  logic [6:0] KB_data;
  logic       buf_full;

  int errors;
  int checks;

  keyboard_buf #(.DEPTH(16), .PTR_W(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .KB_read_en (KB_read_en),
    .KB_clear   (KB_clear),
    .rx_data    (rx_data),
    .rx_done    (rx_done),
    .KB_status  (KB_status),
    .KB_data    (KB_data),
    .buf_full   (buf_full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %02h expected %02h", tag, got, exp);
    end
  endtask

  task automatic check_state(input string tag, input logic st, input logic [6:0] data,
                             input logic fl);
    check({tag, "_status"}, {7'b0, KB_status}, {7'b0, st});
    check({tag, "_data"}, {1'b0, KB_data}, {1'b0, data});
    check({tag, "_full"}, {7'b0, buf_full}, {7'b0, fl});
  endtask

  task automatic push(input logic [7:0] b);
    @(negedge clk);
    rx_data = b;
    rx_done = 1'b1;
    @(negedge clk);
    rx_done = 1'b0;
  endtask

  task automatic pop();
    @(negedge clk);
    KB_read_en = 1'b1;
    @(negedge clk);
    KB_read_en = 1'b0;
  endtask

  task automatic clear();
    @(negedge clk);
    KB_clear = 1'b1;
    @(negedge clk);
    KB_clear = 1'b0;
  endtask

  initial begin
    errors     = 0;
    checks     = 0;
    reset      = 1'b1;
    KB_read_en = 1'b0;
    KB_clear   = 1'b0;
    rx_data    = 8'h00;
    rx_done    = 1'b0;

    @(negedge clk);
    check_state("reset", 1'b0, 7'h00, 1'b0);
    reset = 1'b0;

    // rx_done held for three cycles queues exactly one character
    @(negedge clk);
    rx_data = 8'h68;
    rx_done = 1'b1;
    repeat (3) @(negedge clk);
    rx_done = 1'b0;
    check_state("held_push", 1'b1, 7'h68, 1'b0);
    pop();
    check_state("held_pop", 1'b0, 7'h00, 1'b0);

    push(8'h68);
    push(8'h65);
    check("two_head0", {1'b0, KB_data}, 8'h68);
    pop();
    check("two_head1", {1'b0, KB_data}, 8'h65);
    pop();
    check_state("two_empty", 1'b0, 7'h00, 1'b0);

    push(8'hE5);
    check("bit7_strip", {1'b0, KB_data}, 8'h65);
    pop();

    for (int i = 1; i <= 16; i++) push(8'(i));
    check_state("fill16", 1'b1, 7'h01, 1'b1);
    push(8'h11);
    check_state("overflow", 1'b1, 7'h01, 1'b1);
    for (int i = 1; i <= 16; i++) begin
      check("fifo_order", {1'b0, KB_data}, 8'(i));
      pop();
      if (i == 1) check("full_drop", {7'b0, buf_full}, 8'h00);
    end
    check_state("drain16", 1'b0, 7'h00, 1'b0);

    // simultaneous push+pop with 3 entries: count held, head advances
    push(8'h21);
    push(8'h22);
    push(8'h23);
    @(negedge clk);
    rx_data    = 8'h24;
    rx_done    = 1'b1;
    KB_read_en = 1'b1;
    @(negedge clk);
    rx_done    = 1'b0;
    KB_read_en = 1'b0;
    check_state("simul3", 1'b1, 7'h22, 1'b0);
    pop();
    check("simul3_q1", {1'b0, KB_data}, 8'h23);
    pop();
    check("simul3_q2", {1'b0, KB_data}, 8'h24);
    pop();
    check("simul3_empty", {7'b0, KB_status}, 8'h00);

    // simultaneous on empty: push only
    @(negedge clk);
    rx_data    = 8'h41;
    rx_done    = 1'b1;
    KB_read_en = 1'b1;
    @(negedge clk);
    rx_done    = 1'b0;
    KB_read_en = 1'b0;
    check_state("simul_empty", 1'b1, 7'h41, 1'b0);
    pop();
    check("simul_empty_drain", {7'b0, KB_status}, 8'h00);

    // simultaneous on full: pop only, push dropped
    for (int i = 1; i <= 16; i++) push(8'(i));
    @(negedge clk);
    rx_data    = 8'h55;
    rx_done    = 1'b1;
    KB_read_en = 1'b1;
    @(negedge clk);
    rx_done    = 1'b0;
    KB_read_en = 1'b0;
    check_state("simul_full", 1'b1, 7'h02, 1'b0);
    clear();
    check_state("clear_full", 1'b0, 7'h00, 1'b0);

    // clear wins over a push in the same cycle
    push(8'h21);
    push(8'h22);
    push(8'h23);
    @(negedge clk);
    rx_data  = 8'h30;
    rx_done  = 1'b1;
    KB_clear = 1'b1;
    @(negedge clk);
    rx_done  = 1'b0;
    KB_clear = 1'b0;
    check_state("clear_push", 1'b0, 7'h00, 1'b0);
    push(8'h31);
    check_state("after_clear", 1'b1, 7'h31, 1'b0);
    pop();

    // asynchronous reset between edges with 5 entries queued
    for (int i = 0; i < 5; i++) push(8'h50 + 8'(i));
    check_state("pre_reset", 1'b1, 7'h50, 1'b0);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check_state("async_reset", 1'b0, 7'h00, 1'b0);
    #1 reset = 1'b0;
    repeat (2) @(negedge clk);
    check_state("post_reset", 1'b0, 7'h00, 1'b0);
    push(8'h7A);
    check_state("resume", 1'b1, 7'h7A, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
